// File: rtl/dec16_timer_if.sv
// Control and status bundle for the dec16_timer countdown primitive.
// master drives load/start/stop/tick controls; slave (the timer) returns count and flags.
interface dec16_timer_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             tick;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;

  modport master (
    output load, load_value, start, stop, tick, auto_reload,
    input  count, busy, done, zero
  );

  modport slave (
    input  load, load_value, start, stop, tick, auto_reload,
    output count, busy, done, zero
  );
endinterface

// File: rtl/dec16_timer.sv
// Loadable down-counter/timer with terminal-count done pulse and optional auto-reload.
// Define DEC16_PRESCALE_EN to derive ticks from an internal PRESCALE-cycle divider instead of the tick port.
module dec16_timer #(
  parameter int WIDTH = 16
`ifdef DEC16_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input logic            clk,
  input logic            reset_n,
  dec16_timer_if.slave   bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [0:0]       state_p0;
  logic [WIDTH-1:0] count_p0;
  logic [WIDTH-1:0] reload_p0;
  logic             done_p0;
  logic             tick_en;
  logic             running;

  assign running = (state_p0 == ST_RUN);

`ifdef DEC16_PRESCALE_EN
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  logic [15:0] presc_p0;
  logic        unused_tick;

  assign unused_tick = bus.tick;
  assign tick_en     = running && (presc_p0 == PS_LAST);

  // Divider only advances on cycles where no higher-priority control acts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_p0 <= '0;
    end else if (bus.load || bus.stop || (bus.start && !running)) begin
      presc_p0 <= '0;
    end else if (running) begin
      presc_p0 <= (presc_p0 == PS_LAST) ? '0 : presc_p0 + 16'd1;
    end
  end
`else
  assign tick_en = running && bus.tick;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_p0  <= ST_IDLE;
      count_p0  <= '0;
      reload_p0 <= '0;
      done_p0   <= 1'b0;
    end else begin
      done_p0 <= 1'b0;
      if (bus.load) begin
        count_p0  <= bus.load_value;
        reload_p0 <= bus.load_value;
        state_p0  <= ST_IDLE;
      end else if (bus.stop) begin
        state_p0 <= ST_IDLE;
      end else if (bus.start && !running) begin
        // Starting from zero would never terminate, so it is ignored.
        if (count_p0 != '0) state_p0 <= ST_RUN;
      end else if (tick_en) begin
        if (count_p0 == ONE) begin
          done_p0 <= 1'b1;
          if (bus.auto_reload && (reload_p0 != '0)) begin
            count_p0 <= reload_p0;
          end else begin
            count_p0 <= '0;
            state_p0 <= ST_IDLE;
          end
        end else begin
          count_p0 <= count_p0 - ONE;
        end
      end
    end
  end

  assign bus.count = count_p0;
  assign bus.busy  = running;
  assign bus.done  = done_p0;
  assign bus.zero  = (count_p0 == '0);
endmodule

// File: tb/tb_dec16_timer.sv
// Directed scoreboard bench for dec16_timer: each step queues its expected outputs,
// then pops and checks them one edge later.
module tb_dec16_timer;
  logic clk = 1'b0;
  logic reset_n;

  dec16_timer_if #(.WIDTH(16)) bif ();

  dec16_timer #(.WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] count;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic step(input string tag, input logic rn, input logic ld, input logic [15:0] lv,
                      input logic st, input logic sp, input logic tk, input logic ar,
                      input logic [15:0] e_count, input logic e_busy, input logic e_done);
    exp_t e;
    exp_t got;
    logic e_zero;
    e.tag = tag; e.count = e_count; e.busy = e_busy; e.done = e_done;
    sb.push_back(e);
    reset_n = rn; bif.load = ld; bif.load_value = lv; bif.start = st;
    bif.stop = sp; bif.tick = tk; bif.auto_reload = ar;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    e_zero = (got.count == 16'h0000);
    vectors++;
    assert (bif.count === got.count) else begin
      miscompares++;
      $error("FAIL %s count observed=%h expected=%h", got.tag, bif.count, got.count);
    end
    vectors++;
    assert (bif.busy === got.busy) else begin
      miscompares++;
      $error("FAIL %s busy observed=%b expected=%b", got.tag, bif.busy, got.busy);
    end
    vectors++;
    assert (bif.done === got.done) else begin
      miscompares++;
      $error("FAIL %s done observed=%b expected=%b", got.tag, bif.done, got.done);
    end
    vectors++;
    assert (bif.zero === e_zero) else begin
      miscompares++;
      $error("FAIL %s zero observed=%b expected=%b", got.tag, bif.zero, e_zero);
    end
  endtask

  initial begin
    reset_n = 1'b0; bif.load = 1'b0; bif.load_value = '0; bif.start = 1'b0;
    bif.stop = 1'b0; bif.tick = 1'b0; bif.auto_reload = 1'b0;
    //   tag          rn ld lv       st sp tk ar   count    busy done
    step("rst0",      0, 0, 16'h0,   0, 0, 0, 0,   16'h0,   0, 0);
    step("rst1",      0, 0, 16'h0,   0, 0, 0, 0,   16'h0,   0, 0);
`ifdef DEC16_PRESCALE_EN
    step("ps_load",   1, 1, 16'd2,   0, 0, 0, 0,   16'd2,   0, 0);
    step("ps_start",  1, 0, 16'd0,   1, 0, 1, 0,   16'd2,   1, 0);
    for (int i = 0; i < 3; i++)
      step("ps_hold2", 1, 0, 16'd0,  0, 0, i[0], 0, 16'd2,  1, 0);
    for (int i = 0; i < 4; i++)
      step("ps_cnt1",  1, 0, 16'd0,  0, 0, ~i[0], 0, 16'd1, 1, 0);
    step("ps_term",   1, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 1);
    step("ps_after",  1, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 0);
`else
    // Reset in the middle of a run.
    step("mr_load",   1, 1, 16'd5,   0, 0, 0, 0,   16'd5,   0, 0);
    step("mr_start",  1, 0, 16'd0,   1, 0, 0, 0,   16'd5,   1, 0);
    step("mr_hold",   1, 0, 16'd0,   0, 0, 0, 0,   16'd5,   1, 0);
    step("mr_rst0",   0, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 0);
    step("mr_rst1",   0, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 0);
    step("mr_post0",  1, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 0);
    step("mr_post1",  1, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 0);
    // Single-shot countdown from 3.
    step("c3_load",   1, 1, 16'd3,   0, 0, 0, 0,   16'd3,   0, 0);
    step("c3_start",  1, 0, 16'd0,   1, 0, 0, 0,   16'd3,   1, 0);
    step("c3_dec2",   1, 0, 16'd0,   0, 0, 1, 0,   16'd2,   1, 0);
    step("c3_dec1",   1, 0, 16'd0,   0, 0, 1, 0,   16'd1,   1, 0);
    step("c3_term",   1, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 1);
    step("c3_idle",   1, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 0);
    // Auto-reload period 2, then dropping auto_reload mid-run.
    step("ar_load",   1, 1, 16'd2,   0, 0, 0, 0,   16'd2,   0, 0);
    step("ar_start",  1, 0, 16'd0,   1, 0, 0, 1,   16'd2,   1, 0);
    for (int i = 0; i < 3; i++) begin
      step("ar_dec",   1, 0, 16'd0,  0, 0, 1, 1,   16'd1,   1, 0);
      step("ar_rel",   1, 0, 16'd0,  0, 0, 1, 1,   16'd2,   1, 1);
    end
    step("ar_off1",   1, 0, 16'd0,   0, 0, 1, 0,   16'd1,   1, 0);
    step("ar_offt",   1, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 1);
    // Reload value 1 pulses done on every tick.
    step("r1_load",   1, 1, 16'd1,   0, 0, 0, 1,   16'd1,   0, 0);
    step("r1_start",  1, 0, 16'd0,   1, 0, 0, 1,   16'd1,   1, 0);
    step("r1_t0",     1, 0, 16'd0,   0, 0, 1, 1,   16'd1,   1, 1);
    step("r1_t1",     1, 0, 16'd0,   0, 0, 1, 1,   16'd1,   1, 1);
    step("r1_stop",   1, 0, 16'd0,   0, 1, 1, 1,   16'd1,   0, 0);
    // Tick qualification on a large value.
    step("bq_load",   1, 1, 16'h8000, 0, 0, 0, 0,  16'h8000, 0, 0);
    step("bq_start",  1, 0, 16'd0,   1, 0, 0, 0,   16'h8000, 1, 0);
    step("bq_t1a",    1, 0, 16'd0,   0, 0, 1, 0,   16'h7FFF, 1, 0);
    step("bq_t0a",    1, 0, 16'd0,   0, 0, 0, 0,   16'h7FFF, 1, 0);
    step("bq_t1b",    1, 0, 16'd0,   0, 0, 1, 0,   16'h7FFE, 1, 0);
    step("bq_t0b",    1, 0, 16'd0,   0, 0, 0, 0,   16'h7FFE, 1, 0);
    step("bq_t1c",    1, 0, 16'd0,   0, 0, 1, 0,   16'h7FFD, 1, 0);
    step("bq_stop",   1, 0, 16'd0,   0, 1, 0, 0,   16'h7FFD, 0, 0);
    // stop together with the terminal tick.
    step("st_load",   1, 1, 16'd2,   0, 0, 0, 0,   16'd2,   0, 0);
    step("st_start",  1, 0, 16'd0,   1, 0, 0, 0,   16'd2,   1, 0);
    step("st_dec",    1, 0, 16'd0,   0, 0, 1, 0,   16'd1,   1, 0);
    step("st_stopt",  1, 0, 16'd0,   0, 1, 1, 0,   16'd1,   0, 0);
    step("st_idle",   1, 0, 16'd0,   0, 0, 1, 0,   16'd1,   0, 0);
    // start with count zero is ignored.
    step("z_load",    1, 1, 16'd0,   0, 0, 0, 0,   16'd0,   0, 0);
    step("z_start",   1, 0, 16'd0,   1, 0, 1, 0,   16'd0,   0, 0);
    step("z_after",   1, 0, 16'd0,   0, 0, 1, 0,   16'd0,   0, 0);
    // load aborts a run; load beats start; start in RUN keeps counting.
    step("la_load",   1, 1, 16'd4,   0, 0, 0, 0,   16'd4,   0, 0);
    step("la_start",  1, 0, 16'd0,   1, 0, 0, 0,   16'd4,   1, 0);
    step("la_dec",    1, 0, 16'd0,   0, 0, 1, 0,   16'd3,   1, 0);
    step("la_abort",  1, 1, 16'd9,   0, 0, 1, 0,   16'd9,   0, 0);
    step("ls_both",   1, 1, 16'd6,   1, 0, 1, 0,   16'd6,   0, 0);
    step("ls_idle",   1, 0, 16'd0,   0, 0, 1, 0,   16'd6,   0, 0);
    step("sr_start",  1, 0, 16'd0,   1, 0, 0, 0,   16'd6,   1, 0);
    step("sr_again",  1, 0, 16'd0,   1, 0, 1, 0,   16'd5,   1, 0);
    // Modulo decrement near the top of the range.
    step("mx_load",   1, 1, 16'hFFFF, 0, 0, 0, 0,  16'hFFFF, 0, 0);
    step("mx_start",  1, 0, 16'd0,   1, 0, 0, 0,   16'hFFFF, 1, 0);
    step("mx_dec",    1, 0, 16'd0,   0, 0, 1, 0,   16'hFFFE, 1, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dec16_timer.md
Name: dec16_timer

Overview:
- 16-bit loadable down-counter/timer: the decrementing counterpart of the Inc16 incrementer, with sequential control.
- Counts a loaded value down to zero on qualified ticks.
- Pulses done on terminal count, with optional auto-reload for periodic events.
- Sits beside the PC/register blocks as the team's generic countdown/delay primitive.

Parameters:
- WIDTH, 16, counter and load-value width in bits.
- PRESCALE, 4, cycles per internal tick; used only when DEC16_PRESCALE_EN is defined; legal range 1 to 65535.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- load  input  1  load load_value into count and reload register.
- load_value  input  WIDTH  value captured on load.
- start  input  1  begin counting from current count.
- stop  input  1  halt counting; count held.
- tick  input  1  decrement qualifier; one decrement per cycle with tick=1 while running.
- auto_reload  input  1  on terminal count, reload and keep running instead of stopping.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  1 while in RUN.
- done  output  1  one-cycle registered pulse at terminal count.
- zero  output  1  combinational (count == 0).

Behaviour:
- States: IDLE, RUN. Internal reload_reg[WIDTH-1:0].
- Reset (reset_n=0 at a clk edge):
  - count=0, reload_reg=0, state=IDLE, busy=0, done=0.
  - zero=1 follows from count=0.
  - Reset mid-RUN aborts with no done pulse.
- Priority per edge: reset > load > stop > start > tick decrement.
- load (any state):
  - count<=load_value, reload_reg<=load_value, state<=IDLE, done<=0.
  - load during RUN aborts the run with no done pulse.
- stop in RUN: state<=IDLE, count unchanged, done<=0. stop in IDLE: no effect.
- start in IDLE:
  - If count!=0: state<=RUN; busy=1 from the next cycle.
  - If count==0: ignored; stays IDLE, no done pulse.
- start in RUN: no effect.
- RUN, tick=1, count>1: count<=count-1.
- RUN, tick=1, count==1 (terminal):
  - done<=1 for exactly one cycle, coincident with the updated count.
  - If auto_reload=1 and reload_reg!=0: count<=reload_reg, stay RUN.
  - Otherwise: count<=0, state<=IDLE, busy<=0.
- RUN, tick=0: count held.
- done is 0 in every cycle that does not follow a terminal event.
- auto_reload is sampled only at the terminal edge; changing it mid-run is legal.
- reload_reg=1 with auto_reload=1: done pulses on every tick while running.
- Arithmetic:
  - Decrement is modulo 2^WIDTH, but RUN never decrements from 0.
  - count never underflows; count==0 in RUN is unreachable.
- Latency:
  - count changes the cycle after the qualifying edge inputs are sampled.
  - busy rises one cycle after the accepted start.
- Simultaneous inputs:
  - load+start on the same edge: load wins; state IDLE; a fresh start is needed.
  - stop+terminal tick on the same edge: stop wins; count held at 1, no done.

Optional Feature:
- Macro DEC16_PRESCALE_EN.
- Defined:
  - tick input is ignored.
  - An internal prescaler counts 0..PRESCALE-1 while in RUN and generates an internal tick on wrap.
  - The prescaler clears on reset, load, stop, and accepted start.
  - First decrement occurs PRESCALE cycles after busy rises.
- Not defined:
  - No prescaler logic; decrement qualified directly by the tick port as above.

Test Plan:
- Reset with reset_n=0 for 2 cycles mid-count (count=0x0005 in RUN) -> count=0, busy=0, done=0, zero=1; no done pulse afterwards.
- load 3, start, tick held 1 -> count 3,2,1,0 on successive cycles; done=1 only in the cycle count becomes 0; busy drops that cycle; zero=1.
- load 2, auto_reload=1, start, tick=1 for 6 cycles -> count 2,1,2,1,2,1 pattern; done pulses each time count returns to 2; busy stays 1.
- load 0x8000, start, tick toggling 1/0 -> count decrements only on tick=1 cycles (0x7FFF, hold, 0x7FFE...); no wrap past 0.
- count=1 in RUN, stop and tick asserted together -> count stays 1, done=0, busy=0. Separately, start with count=0 -> stays IDLE, done=0.
- With DEC16_PRESCALE_EN, PRESCALE=4: load 2, start -> count 2 for 4 cycles, then 1 for 4 cycles, then 0 with done pulse; tick port toggling has no effect.
